// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the MAC configuration fabric: loader FSM states and
// default MAC widths from which the shift-chain length is derived.
package fabric_cfg_pkg;

  localparam int MAC_ACC_WIDTH  = 32;
  localparam int MAC_CONF_WIDTH = 4;
  localparam int MAC_WORD_WIDTH = 32;
  localparam int MAC_CHAIN_LEN  = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SET,
    FIN
  } loader_state_t;

endpackage

// File: rtl/mac_config_loader_if.sv
// Configuration word handshake between a word source (master) and the loader (slave).
interface mac_config_loader_if #(
  parameter int WORD_WIDTH = 32
);

  logic [WORD_WIDTH-1:0] cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/cfg_word_serializer.sv
// Holds one configuration word and presents its bits LSB first, one per advance.
module cfg_word_serializer #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  advance,
  input  logic                  enable,
  output logic                  last_bit,
  output logic                  shift_in
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] word_reg;
  logic [IDX_W-1:0]      idx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (load) begin
      word_reg <= data;
      idx_reg  <= '0;
    end else if (advance) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  assign last_bit = (idx_reg == IDX_W'(WORD_WIDTH - 1));
  // Forced low whenever the chain is not being shifted.
  assign shift_in = enable & word_reg[idx_reg];

endmodule

// File: rtl/mac_config_loader.sv
// Streams configuration words into a MAC shift chain and latches it with cset.
// Optional parity check against exp_parity is enabled by defining MAC_CFG_PARITY_EN.
module mac_config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_WIDTH = MAC_WORD_WIDTH,
  parameter int CHAIN_LEN  = MAC_CHAIN_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                exp_parity,
  mac_config_loader_if.slave  cfg,
  output logic                cen,
  output logic                shift_in,
  output logic                cset,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  loader_state_t    state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic             accept;
  logic             capture;
  logic             cfg_ready;
  logic             last_bit;
  logic             parity_ok;

  assign cfg.cfg_ready = cfg_ready;

  cfg_word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .data     (cfg.cfg_data),
    .advance  (cen),
    .enable   (cen),
    .last_bit (last_bit),
    .shift_in (shift_in)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        bit_cnt_reg <= '0;
      end else if (cen) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // Abort gates every outward action in the same cycle so it wins over any handshake.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    cfg_ready  = 1'b0;
    cen        = 1'b0;
    cset       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          cfg_ready = 1'b1;
          if (cfg.cfg_valid) begin
            capture    = 1'b1;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          cen = 1'b1;
          if (bit_cnt_reg == CNT_W'(CHAIN_LEN - 1)) begin
            state_next = SET;
          end else if (last_bit) begin
            state_next = LOAD;
          end
        end
      end
      SET: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          cset       = parity_ok;
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
        done       = !abort;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MAC_CFG_PARITY_EN
  logic err_reg;
  logic exp_par_reg;
  logic par_acc_reg;

  assign parity_ok = (par_acc_reg == exp_par_reg);
  assign err       = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg     <= 1'b0;
      exp_par_reg <= 1'b0;
      par_acc_reg <= 1'b0;
    end else if (accept) begin
      err_reg     <= 1'b0;
      exp_par_reg <= exp_parity;
      par_acc_reg <= 1'b0;
    end else begin
      if (cen) begin
        par_acc_reg <= par_acc_reg ^ shift_in;
      end
      if (state_reg == SET && !abort && !parity_ok) begin
        err_reg <= 1'b1;
      end
    end
  end
`else
  logic unused_exp_parity;

  assign unused_exp_parity = exp_parity;
  assign parity_ok         = 1'b1;
  assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_mac_config_loader.sv
// Scoreboard bench for mac_config_loader: stimulus queues expected bits and
// completion records, a negedge monitor pops and compares them.
module tb_mac_config_loader;

  localparam int WW = 32;
  localparam int CL = 132;

  typedef struct {
    logic cset;
    logic err;
  } end_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic exp_parity = 1'b0;
  logic cen, shift_in, cset, busy, done, err;

  mac_config_loader_if #(.WORD_WIDTH(WW)) cfg_bus ();

  mac_config_loader #(
    .WORD_WIDTH(WW),
    .CHAIN_LEN (CL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .exp_parity (exp_parity),
    .cfg        (cfg_bus),
    .cen        (cen),
    .shift_in   (shift_in),
    .cset       (cset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic     sb_bits[$];
  end_rec_t sb_end[$];
  int       vectors = 0;
  int       miscompares = 0;
  int       shifted_cnt = 0;
  int       done_cnt = 0;
  int       cset_cnt = 0;
  logic [3:0] last4 = '0;
  logic     prev_cen = 1'b0;
  logic     prev_cset = 1'b0;

  logic [31:0] w_a [5] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_A5A5, 32'hCAFE_0001, 32'hFFFF_FFF5};
  logic [31:0] w_b [5] = '{32'h8000_0001, 32'h5555_AAAA, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every shifted bit and every completion against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_cen  = 1'b0;
        prev_cset = 1'b0;
      end else begin
        check("output_gating", {30'd0, cfg_bus.cfg_ready && cen, !cen && shift_in}, 32'd0);
        if (cen) begin
          shifted_cnt++;
          last4 = {last4[2:0], shift_in};
          if (sb_bits.size() == 0) begin
            check("extra_shift_bit", 32'd1, 32'd0);
          end else begin
            check("shift_bit", shift_in, sb_bits.pop_front());
          end
        end
        if (cset) begin
          cset_cnt++;
          check("cset_after_last_bit", {prev_cen, sb_bits.size() == 0}, 2'b11);
        end
        if (done) begin
          done_cnt++;
          if (sb_end.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            end_rec_t rec;
            rec = sb_end.pop_front();
            check("done_after_cset", prev_cset, rec.cset);
            check("done_err", err, rec.err);
            check("done_busy", busy, 1'b0);
          end
        end
        prev_cen  = cen;
        prev_cset = cset;
      end
    end
  end

  task automatic wait_accept(output bit ok);
    int guard = 0;
    while (!cfg_bus.cfg_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ok = cfg_bus.cfg_ready;
    check("word_accept_timeout", ok, 1'b1);
    if (ok) @(posedge clk);
  endtask

  // One load of five words; gap stalls before word 3, glitch pulses start mid-load,
  // abort_at>0 aborts once that many bits have been shifted.
  task automatic do_load(input logic [31:0] w [5], input bit gap, input bit glitch,
                         input bit wrong_par, input int abort_at, input logic [3:0] exp_last4);
    logic par;
    bit   ok;
    int   pushed = 0;
    int   guard;
    int   done_before;
    int   cset_before;
    end_rec_t rec;
    par = (^w[0]) ^ (^w[1]) ^ (^w[2]) ^ (^w[3]) ^ (^w[4][3:0]);
`ifdef MAC_CFG_PARITY_EN
    rec.cset = !wrong_par;
    rec.err  = wrong_par;
`else
    rec.cset = 1'b1;
    rec.err  = 1'b0;
`endif
    @(posedge clk); #1;
    start = 1'b1;
    exp_parity = wrong_par ? ~par : par;
    shifted_cnt = 0;
    done_before = done_cnt;
    cset_before = cset_cnt;
    if (abort_at == 0) sb_end.push_back(rec);
    cfg_bus.cfg_data = w[0];
    cfg_bus.cfg_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("err_cleared_by_start", err, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_accept(ok);
      if (!ok) return;
      for (int k = 0; k < WW; k++) begin
        if (pushed < CL) sb_bits.push_back(w[i][k]);
        pushed++;
      end
      #1;
      if (i == 4) begin
        cfg_bus.cfg_valid = 1'b0;
      end else if (gap && i == 1) begin
        cfg_bus.cfg_valid = 1'b0;
        guard = 0;
        while (!cfg_bus.cfg_ready && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        repeat (10) begin
          @(negedge clk);
          check("gap_ready", cfg_bus.cfg_ready, 1'b1);
          check("gap_cen", cen, 1'b0);
        end
        cfg_bus.cfg_data = w[2];
        cfg_bus.cfg_valid = 1'b1;
      end else begin
        cfg_bus.cfg_data = w[i+1];
      end
      if (glitch && i == 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (abort_at > 0 && i == 2) begin
        guard = 0;
        while (shifted_cnt < abort_at && guard < 200) begin
          @(posedge clk);
          guard++;
        end
        #1;
        abort = 1'b1;
        #1;
        check("abort_cen_same_cycle", cen, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        check("abort_state", {busy, cen, cfg_bus.cfg_ready, cset, done}, 5'b0);
        check("abort_bit_count", shifted_cnt, abort_at);
        sb_bits.delete();
        repeat (8) @(posedge clk);
        check("abort_no_done", done_cnt, done_before);
        check("abort_no_cset", cset_cnt, cset_before);
        return;
      end
    end
    guard = 0;
    while (done_cnt == done_before && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    check("done_seen", done_cnt, done_before + 1);
    check("cen_cycles", shifted_cnt, CL);
    check("final_bits", last4, exp_last4);
    check("cset_count", cset_cnt, cset_before + (rec.cset ? 1 : 0));
    check("bits_drained", sb_bits.size(), 0);
    @(negedge clk);
    check("idle_after_done", {busy, done, cen}, 3'b0);
    check("err_sticky", err, rec.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_bus.cfg_data  = '0;
    cfg_bus.cfg_valid = 1'b0;
    #2;
    check("reset_outputs", {cfg_bus.cfg_ready, cen, shift_in, cset, busy, done, err}, 7'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {cfg_bus.cfg_ready, cen, shift_in, cset, busy, done, err}, 7'b0);

    // Nominal load, stray start mid-load ignored; final word 0xFFFFFFF5 -> 1,0,1,0.
    do_load(w_a, 1'b0, 1'b1, 1'b0, 0, 4'b1010);
    // Backpressure gap before word 3; final word 0x0000000A -> 0,1,0,1.
    do_load(w_b, 1'b1, 1'b0, 1'b0, 0, 4'b0101);
    // Abort after 70 bits, then a full load.
    do_load(w_a, 1'b0, 1'b0, 1'b0, 70, 4'b0000);
    do_load(w_a, 1'b0, 1'b0, 1'b0, 0, 4'b1010);
    // Wrong expected parity, then a clean load that must clear err on start.
    do_load(w_b, 1'b0, 1'b0, 1'b1, 0, 4'b0101);
    do_load(w_a, 1'b0, 1'b0, 1'b0, 0, 4'b1010);

    // start together with abort in IDLE stays idle.
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", {busy, cfg_bus.cfg_ready}, 2'b00);

    // Abort in LOAD beats a simultaneous handshake.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_bus.cfg_data = w_a[0];
    cfg_bus.cfg_valid = 1'b1;
    abort = 1'b1;
    #1;
    check("abort_blocks_ready", cfg_bus.cfg_ready, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    check("abort_in_load", {busy, cen}, 2'b00);
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-shift clears outputs before the next edge.
    begin
      bit ok;
      int guard = 0;
      @(posedge clk); #1;
      start = 1'b1;
      shifted_cnt = 0;
      cfg_bus.cfg_data = w_b[1];
      cfg_bus.cfg_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_accept(ok);
      for (int k = 0; k < WW; k++) sb_bits.push_back(w_b[1][k]);
      #1;
      cfg_bus.cfg_valid = 1'b0;
      while (shifted_cnt < 20 && guard < 100) begin
        @(posedge clk);
        guard++;
      end
      #3;
      check("cen_before_reset", cen, 1'b1);
      rst = 1'b0;
      #1;
      check("async_reset_outputs", {cfg_bus.cfg_ready, cen, shift_in, cset, busy, done, err}, 7'b0);
      sb_bits.delete();
      @(posedge clk); #2;
      rst = 1'b1;
    end

    // A full load after the reset succeeds.
    do_load(w_b, 1'b0, 1'b0, 1'b0, 0, 4'b0101);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb_end.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_config_loader.md
MAC_CONFIG_LOADER -- requirements
Module: mac_config_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: width of each incoming configuration word.
REQ-002 SHALL have parameter CHAIN_LEN, default 132: bit length of the target shift chain (4*MAC_ACC_WIDTH + MAC_CONF_WIDTH for the defaults).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: terminates any load in progress.
REQ-007 SHALL have port cfg_data, input, WORD_WIDTH: configuration word.
REQ-008 SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): word handshake.
REQ-009 SHALL have port cen, output, 1: shift enable driven to the chain.
REQ-010 SHALL have port shift_in, output, 1: serial bit driven to the chain.
REQ-011 SHALL have port cset, output, 1: latch pulse driven to the chain.
REQ-012 SHALL have ports busy (output, 1), done (output, 1) and err (output, 1).
REQ-013 SHALL have port exp_parity, input, 1: expected XOR of all CHAIN_LEN bits, sampled on start.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, SET and FIN.
REQ-015 IDLE: start=1 SHALL move the FSM to LOAD, clear the bit counter, and set busy=1 from the next cycle.
REQ-016 LOAD: cfg_ready=1; a word SHALL be captured when cfg_valid&&cfg_ready, and the FSM SHALL move to SHIFT.
REQ-017 SHIFT: cen=1 and shift_in=word bit k (LSB first), one bit per cycle, every cycle, with no stalls.
REQ-018 SHIFT SHALL return to LOAD after WORD_WIDTH bits, or go to SET once CHAIN_LEN total bits have been shifted; excess bits of the final word SHALL be discarded and never driven.
REQ-019 Words required per load = ceil(CHAIN_LEN/WORD_WIDTH); the bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-020 SET: cset=1 for exactly one cycle and cen=0, then FIN.
REQ-021 FIN: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-022 cfg_ready SHALL be 0 in every state except LOAD; cen SHALL be 0 outside SHIFT; shift_in SHALL be 0 whenever cen=0.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no cset and no done; abort SHALL take priority over every other event, including a simultaneous handshake.
REQ-024 start while busy SHALL be ignored; start and abort together in IDLE SHALL leave the FSM in IDLE.
REQ-025 err SHALL be sticky, and SHALL be cleared only by reset or by an accepted start.

Reset
REQ-026 While rst=0, the FSM SHALL be in IDLE and all outputs (cfg_ready, cen, shift_in, cset, busy, done, err) SHALL be 0, independent of clk.
REQ-027 A reset asserted mid-load SHALL cancel the load; no cset SHALL be emitted; the chain contents are then undefined until a full reload.

Configuration
REQ-028 With MAC_CFG_PARITY_EN defined, the block SHALL accumulate the XOR of all shifted bits; in SET, if it differs from the sampled exp_parity, the block SHALL hold cset=0, set err=1, and still pulse done in FIN.
REQ-029 Without MAC_CFG_PARITY_EN, exp_parity SHALL be ignored, err SHALL be tied to 0, and cset SHALL always pulse.

Structure
REQ-030 The shared package fabric_cfg_pkg SHALL hold the FSM state typedef (loader_state_t) and the default MAC width constants used to derive CHAIN_LEN.
REQ-031 The block SHALL contain one sub-module, cfg_word_serializer (word register, bit index, shift_in output); the FSM and counter SHALL reside in the top-level module.

Verification (WORD_WIDTH=32, CHAIN_LEN=132)
REQ-032 Nominal load: start, then 5 words with cfg_valid held high -> cen high for exactly 132 cycles total, a single cset one cycle after the last bit, done on the following cycle.
REQ-033 Final-word truncation: word 5 = 0xFFFFFFF5 -> final 4 shifted bits are 1,0,1,0; no further cen cycles.
REQ-034 Backpressure: cfg_valid low for 10 cycles between words 2 and 3 -> cen=0 and cfg_ready=1 throughout the gap; shifted bitstream unchanged.
REQ-035 Abort after 70 bits -> next cycle IDLE, cen=0, no cset, no done; a following full load succeeds.
REQ-036 Async reset mid-shift -> all outputs 0 before the next clk edge.
REQ-037 Parity (with MAC_CFG_PARITY_EN): exp_parity deliberately wrong -> cset never asserted, err=1, done pulses; the next start clears err.
